// File: rtl/fifo_param_flags_if.sv
// fifo_param_flags_if
//   Handshake/data bundle for fifo_param_flags. The producer/consumer side
//   uses the master modport (drives in_*), the FIFO uses the slave modport
//   (drives out_*).
//   in_write_ctrl/in_write_data   write request + data
//   in_read_ctrl                  read request (FWFT: pop current head)
//   in_clear_err                  clear sticky error flags
//   out_read_data                 read data
//   out_is_full/out_is_empty      occupancy extremes
//   out_almost_full/_empty        threshold flags
//   out_count                     occupancy, $clog2(DEPTH+1) bits
//   out_overflow/out_underflow    sticky error flags
interface fifo_param_flags_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             in_write_ctrl;
  logic [WIDTH-1:0] in_write_data;
  logic             in_read_ctrl;
  logic             in_clear_err;
  logic [WIDTH-1:0] out_read_data;
  logic             out_is_full;
  logic             out_is_empty;
  logic             out_almost_full;
  logic             out_almost_empty;
  logic [CW-1:0]    out_count;
  logic             out_overflow;
  logic             out_underflow;

  modport master (
    output in_write_ctrl, in_write_data, in_read_ctrl, in_clear_err,
    input  out_read_data, out_is_full, out_is_empty, out_almost_full,
           out_almost_empty, out_count, out_overflow, out_underflow
  );

  modport slave (
    input  in_write_ctrl, in_write_data, in_read_ctrl, in_clear_err,
    output out_read_data, out_is_full, out_is_empty, out_almost_full,
           out_almost_empty, out_count, out_overflow, out_underflow
  );
endinterface

// File: rtl/fifo_param_flags.sv
// fifo_param_flags
//   Single-clock FIFO with configurable width/depth (any DEPTH >= 2),
//   almost-full/almost-empty thresholds, occupancy count, sticky
//   overflow/underflow flags and an optional first-word-fall-through mode.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fifo_param_flags_if.slave (all request/response signals)
module fifo_param_flags #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = 3,
  parameter int AE_THRESH = 1,
  parameter int FWFT      = 0
) (
  input logic              clk,
  input logic              rst_n,
  fifo_param_flags_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
  localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q, count_next;
  logic          full_q, empty_q, af_q, ae_q;
  logic          ovf_q, unf_q;

  logic rd_ok, wr_ok, wr_drop, rd_drop;

  // Explicit wrap so non-power-of-2 depths never index past the array.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + PW'(1);
  endfunction

  // Accept decisions use registered flags only. A write into a full FIFO is
  // still accepted when a read frees a slot in the same cycle; a read from an
  // empty FIFO is never satisfied by a same-cycle write (no bypass).
  always_comb begin
    rd_ok      = bus.in_read_ctrl & ~empty_q;
    wr_ok      = bus.in_write_ctrl & (~full_q | rd_ok);
    wr_drop    = bus.in_write_ctrl & ~wr_ok;
    rd_drop    = bus.in_read_ctrl & empty_q;
    count_next = count_q;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_next = count_q + CW'(1);
      2'b01:   count_next = count_q - CW'(1);
      default: count_next = count_q;
    endcase
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_ok) rd_ptr <= ptr_inc(rd_ptr);
      count_q <= count_next;
    end
  end

  // Status flags are registered from count_next so they line up with count_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
    end else begin
      full_q  <= (count_next == DEPTH_C);
      empty_q <= (count_next == '0);
      af_q    <= (count_next >= AF_C);
      ae_q    <= (count_next <= AE_C);
    end
  end

  // Sticky errors: an error event in the same cycle beats the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wr_drop)               ovf_q <= 1'b1;
      else if (bus.in_clear_err) ovf_q <= 1'b0;
      if (rd_drop)               unf_q <= 1'b1;
      else if (bus.in_clear_err) unf_q <= 1'b0;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= bus.in_write_data;
  end

  generate
    if (FWFT == 0) begin : g_reg_read
      logic [WIDTH-1:0] rdata_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rdata_q <= '0;
        else if (rd_ok) rdata_q <= mem[rd_ptr];
      end
      assign bus.out_read_data = rdata_q;
    end else begin : g_fwft_read
      // Head is shown combinationally from the array while not empty. When
      // empty, the last consumed head is replayed (zero straight out of
      // reset) so the output never exposes unwritten storage.
      logic [WIDTH-1:0] last_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     last_q <= '0;
        else if (rd_ok) last_q <= mem[rd_ptr];
      end
      assign bus.out_read_data = empty_q ? last_q : mem[rd_ptr];
    end
  endgenerate

  assign bus.out_is_full      = full_q;
  assign bus.out_is_empty     = empty_q;
  assign bus.out_almost_full  = af_q;
  assign bus.out_almost_empty = ae_q;
  assign bus.out_count        = count_q;
  assign bus.out_overflow     = ovf_q;
  assign bus.out_underflow    = unf_q;
endmodule

// File: tb/tb_fifo_param_flags.sv
// Directed bench for fifo_param_flags: three instances (DEPTH=4 registered,
// DEPTH=5 registered, DEPTH=4 FWFT) sharing clk/rst_n.
module tb_fifo_param_flags;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  fifo_param_flags_if #(.WIDTH(8), .DEPTH(4)) b4 ();
  fifo_param_flags_if #(.WIDTH(8), .DEPTH(5)) b5 ();
  fifo_param_flags_if #(.WIDTH(8), .DEPTH(4)) bf ();

  fifo_param_flags #(.WIDTH(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1), .FWFT(0))
    u4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  fifo_param_flags #(.WIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .FWFT(0))
    u5 (.clk(clk), .rst_n(rst_n), .bus(b5));
  fifo_param_flags #(.WIDTH(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1))
    uf (.clk(clk), .rst_n(rst_n), .bus(bf));

  // advance one clock, then settle away from the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    b4.in_write_ctrl = 0; b4.in_read_ctrl = 0; b4.in_clear_err = 0; b4.in_write_data = '0;
    b5.in_write_ctrl = 0; b5.in_read_ctrl = 0; b5.in_clear_err = 0; b5.in_write_data = '0;
    bf.in_write_ctrl = 0; bf.in_read_ctrl = 0; bf.in_clear_err = 0; bf.in_write_data = '0;
  endtask

  // flag vector order: {full, empty, almost_full, almost_empty, overflow, underflow}
  task automatic test_reset();
    logic [5:0] f;
    idle_all();
    rst_n = 0;
    #12;
    f = {b4.out_is_full, b4.out_is_empty, b4.out_almost_full, b4.out_almost_empty,
         b4.out_overflow, b4.out_underflow};
    n_chk++;
    if (f !== 6'b010100) begin n_fail++; $display("FAIL reset_flags4: got %b want %b", f, 6'b010100); end
    n_chk++;
    if (b4.out_count !== 3'd0) begin n_fail++; $display("FAIL reset_count4: got %0d want 0", b4.out_count); end
    n_chk++;
    if (b4.out_read_data !== 8'h00) begin n_fail++; $display("FAIL reset_rdata4: got %h want 00", b4.out_read_data); end
    @(negedge clk);
    rst_n = 1;
    cyc();
    f = {b5.out_is_full, b5.out_is_empty, b5.out_almost_full, b5.out_almost_empty,
         b5.out_overflow, b5.out_underflow};
    n_chk++;
    if (f !== 6'b010100) begin n_fail++; $display("FAIL reset_flags5: got %b want %b", f, 6'b010100); end
    n_chk++;
    if (bf.out_read_data !== 8'h00 || bf.out_is_empty !== 1'b1) begin
      n_fail++; $display("FAIL reset_fwft: got data %h empty %b want 00 1", bf.out_read_data, bf.out_is_empty);
    end
  endtask

  task automatic test_fill_drain();
    logic [3:0] f, e;
    logic [7:0] d;
    for (int i = 0; i < 4; i++) begin
      b4.in_write_ctrl = 1; b4.in_write_data = 8'hA0 + 8'(i);
      cyc();
      f = {b4.out_is_full, b4.out_is_empty, b4.out_almost_full, b4.out_almost_empty};
      e = {(i == 3), 1'b0, (i >= 2), (i == 0)};
      n_chk++;
      if (f !== e || b4.out_count !== 3'(i + 1)) begin
        n_fail++; $display("FAIL fill_%0d: got flags %b count %0d want %b %0d", i, f, b4.out_count, e, i + 1);
      end
    end
    b4.in_write_ctrl = 0;
    for (int i = 0; i < 4; i++) begin
      b4.in_read_ctrl = 1;
      cyc();
      d = 8'hA0 + 8'(i);
      f = {b4.out_is_full, b4.out_is_empty, b4.out_almost_full, b4.out_almost_empty};
      e = {1'b0, (i == 3), (i == 0), (i >= 2)};
      n_chk++;
      if (b4.out_read_data !== d || f !== e || b4.out_count !== 3'(3 - i)) begin
        n_fail++; $display("FAIL drain_%0d: got data %h flags %b count %0d want %h %b %0d",
                           i, b4.out_read_data, f, b4.out_count, d, e, 3 - i);
      end
    end
    b4.in_read_ctrl = 0;
    cyc();
    n_chk++;
    if (b4.out_read_data !== 8'hA3) begin n_fail++; $display("FAIL drain_hold: got %h want a3", b4.out_read_data); end
  endtask

  task automatic test_full_rw();
    logic [7:0] exp_d [4];
    exp_d = '{8'hB1, 8'hB2, 8'hB3, 8'hC0};
    for (int i = 0; i < 4; i++) begin
      b4.in_write_ctrl = 1; b4.in_write_data = 8'hB0 + 8'(i);
      cyc();
    end
    // write + read while full: both accepted
    b4.in_write_data = 8'hC0; b4.in_read_ctrl = 1;
    cyc();
    n_chk++;
    if (b4.out_count !== 3'd4 || b4.out_is_full !== 1'b1 || b4.out_overflow !== 1'b0 || b4.out_read_data !== 8'hB0) begin
      n_fail++; $display("FAIL full_rw: got count %0d full %b ovf %b data %h want 4 1 0 b0",
                         b4.out_count, b4.out_is_full, b4.out_overflow, b4.out_read_data);
    end
    // write alone while full: dropped
    b4.in_write_data = 8'hD0; b4.in_read_ctrl = 0;
    cyc();
    n_chk++;
    if (b4.out_overflow !== 1'b1 || b4.out_count !== 3'd4) begin
      n_fail++; $display("FAIL overflow_set: got ovf %b count %0d want 1 4", b4.out_overflow, b4.out_count);
    end
    b4.in_write_ctrl = 0;
    for (int i = 0; i < 4; i++) begin
      b4.in_read_ctrl = 1;
      cyc();
      n_chk++;
      if (b4.out_read_data !== exp_d[i]) begin
        n_fail++; $display("FAIL full_order_%0d: got %h want %h", i, b4.out_read_data, exp_d[i]);
      end
    end
    b4.in_read_ctrl = 0;
    cyc();
    n_chk++;
    if (b4.out_is_empty !== 1'b1 || b4.out_overflow !== 1'b1) begin
      n_fail++; $display("FAIL overflow_sticky: got empty %b ovf %b want 1 1", b4.out_is_empty, b4.out_overflow);
    end
    b4.in_clear_err = 1;
    cyc();
    b4.in_clear_err = 0;
    n_chk++;
    if (b4.out_overflow !== 1'b0) begin n_fail++; $display("FAIL overflow_clear: got %b want 0", b4.out_overflow); end
  endtask

  task automatic test_underflow();
    b4.in_read_ctrl = 1;
    cyc();
    n_chk++;
    if (b4.out_underflow !== 1'b1 || b4.out_count !== 3'd0 || b4.out_read_data !== 8'hC0) begin
      n_fail++; $display("FAIL underflow_set: got unf %b count %0d data %h want 1 0 c0",
                         b4.out_underflow, b4.out_count, b4.out_read_data);
    end
    b4.in_read_ctrl = 0; b4.in_clear_err = 1;
    cyc();
    n_chk++;
    if (b4.out_underflow !== 1'b0) begin n_fail++; $display("FAIL underflow_clear: got %b want 0", b4.out_underflow); end
    b4.in_read_ctrl = 1;  // clear and event together: event wins
    cyc();
    n_chk++;
    if (b4.out_underflow !== 1'b1) begin n_fail++; $display("FAIL clear_vs_event: got %b want 1", b4.out_underflow); end
    // empty + write + read: write taken, read ignored, no bypass
    b4.in_clear_err = 0; b4.in_write_ctrl = 1; b4.in_write_data = 8'h77;
    cyc();
    n_chk++;
    if (b4.out_count !== 3'd1 || b4.out_is_empty !== 1'b0 || b4.out_underflow !== 1'b1 || b4.out_read_data !== 8'hC0) begin
      n_fail++; $display("FAIL empty_rw: got count %0d empty %b unf %b data %h want 1 0 1 c0",
                         b4.out_count, b4.out_is_empty, b4.out_underflow, b4.out_read_data);
    end
    b4.in_write_ctrl = 0;
    cyc();
    n_chk++;
    if (b4.out_read_data !== 8'h77 || b4.out_is_empty !== 1'b1) begin
      n_fail++; $display("FAIL empty_rw_read: got data %h empty %b want 77 1", b4.out_read_data, b4.out_is_empty);
    end
    b4.in_read_ctrl = 0; b4.in_clear_err = 1;
    cyc();
    b4.in_clear_err = 0;
  endtask

  task automatic test_wrap();
    logic [7:0] q [$];
    logic [7:0] exp_d;
    bit rd, rok, wok;
    for (int i = 0; i < 12; i++) begin
      rd = (i % 3 != 0);
      b5.in_write_ctrl = 1; b5.in_write_data = 8'h10 + 8'(i); b5.in_read_ctrl = rd;
      rok = rd && (q.size() > 0);
      wok = (q.size() < 5) || rok;
      exp_d = 8'h00;
      if (rok) exp_d = q.pop_front();
      if (wok) q.push_back(8'h10 + 8'(i));
      cyc();
      n_chk++;
      if (b5.out_count !== 3'(q.size()) || (rok && b5.out_read_data !== exp_d)) begin
        n_fail++; $display("FAIL wrap_%0d: got count %0d data %h want %0d %h", i, b5.out_count, b5.out_read_data, q.size(), exp_d);
      end
    end
    b5.in_read_ctrl = 0;
    // top up to full across the wrapped pointers
    while (q.size() < 5) begin
      b5.in_write_data = 8'h40 + 8'(q.size());
      q.push_back(b5.in_write_data);
      cyc();
    end
    b5.in_write_ctrl = 0;
    n_chk++;
    if (b5.out_is_full !== 1'b1 || b5.out_almost_full !== 1'b1 || b5.out_count !== 3'd5) begin
      n_fail++; $display("FAIL wrap_full: got full %b af %b count %0d want 1 1 5", b5.out_is_full, b5.out_almost_full, b5.out_count);
    end
    for (int i = 0; i < 5; i++) begin
      b5.in_read_ctrl = 1;
      exp_d = q.pop_front();
      cyc();
      n_chk++;
      if (b5.out_read_data !== exp_d) begin
        n_fail++; $display("FAIL wrap_drain_%0d: got %h want %h", i, b5.out_read_data, exp_d);
      end
    end
    b5.in_read_ctrl = 0;
    cyc();
    n_chk++;
    if (b5.out_is_empty !== 1'b1 || b5.out_underflow !== 1'b0 || b5.out_overflow !== 1'b0) begin
      n_fail++; $display("FAIL wrap_end: got empty %b unf %b ovf %b want 1 0 0", b5.out_is_empty, b5.out_underflow, b5.out_overflow);
    end
  endtask

  task automatic test_fwft();
    bf.in_write_ctrl = 1; bf.in_write_data = 8'h5A;
    cyc();
    n_chk++;
    if (bf.out_read_data !== 8'h5A || bf.out_is_empty !== 1'b0) begin
      n_fail++; $display("FAIL fwft_first: got data %h empty %b want 5a 0", bf.out_read_data, bf.out_is_empty);
    end
    bf.in_write_data = 8'h6B;
    cyc();
    n_chk++;
    if (bf.out_read_data !== 8'h5A || bf.out_count !== 3'd2) begin
      n_fail++; $display("FAIL fwft_hold: got data %h count %0d want 5a 2", bf.out_read_data, bf.out_count);
    end
    bf.in_write_ctrl = 0; bf.in_read_ctrl = 1;
    cyc();
    n_chk++;
    if (bf.out_read_data !== 8'h6B || bf.out_count !== 3'd1) begin
      n_fail++; $display("FAIL fwft_next: got data %h count %0d want 6b 1", bf.out_read_data, bf.out_count);
    end
    cyc();
    n_chk++;
    if (bf.out_is_empty !== 1'b1 || bf.out_read_data !== 8'h6B || bf.out_underflow !== 1'b0) begin
      n_fail++; $display("FAIL fwft_empty: got empty %b data %h unf %b want 1 6b 0", bf.out_is_empty, bf.out_read_data, bf.out_underflow);
    end
    cyc();
    bf.in_read_ctrl = 0;
    n_chk++;
    if (bf.out_underflow !== 1'b1 || bf.out_count !== 3'd0) begin
      n_fail++; $display("FAIL fwft_underflow: got unf %b count %0d want 1 0", bf.out_underflow, bf.out_count);
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] f;
    b4.in_read_ctrl = 1;  // leave an underflow pending so reset has something to clear
    cyc();
    b4.in_read_ctrl = 0;
    for (int i = 0; i < 3; i++) begin
      b4.in_write_ctrl = 1; b4.in_write_data = 8'hE0 + 8'(i);
      cyc();
    end
    n_chk++;
    if (b4.out_count !== 3'd3 || b4.out_almost_full !== 1'b1 || b4.out_underflow !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset: got count %0d af %b unf %b want 3 1 1", b4.out_count, b4.out_almost_full, b4.out_underflow);
    end
    b4.in_write_data = 8'hE3;
    #2 rst_n = 0;
    #1;
    f = {b4.out_is_full, b4.out_is_empty, b4.out_almost_full, b4.out_almost_empty,
         b4.out_overflow, b4.out_underflow};
    n_chk++;
    if (f !== 6'b010100 || b4.out_count !== 3'd0 || b4.out_read_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_mid: got flags %b count %0d data %h want 010100 0 00", f, b4.out_count, b4.out_read_data);
    end
    idle_all();
    @(negedge clk);
    rst_n = 1;
    cyc();
    b4.in_write_ctrl = 1; b4.in_write_data = 8'hF0;
    cyc();
    b4.in_write_data = 8'hF1;
    cyc();
    b4.in_write_ctrl = 0; b4.in_read_ctrl = 1;
    cyc();
    n_chk++;
    if (b4.out_read_data !== 8'hF0) begin n_fail++; $display("FAIL post_reset_0: got %h want f0", b4.out_read_data); end
    cyc();
    b4.in_read_ctrl = 0;
    n_chk++;
    if (b4.out_read_data !== 8'hF1 || b4.out_is_empty !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_1: got data %h empty %b want f1 1", b4.out_read_data, b4.out_is_empty);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_rw();
    test_underflow();
    test_wrap();
    test_fwft();
    test_reset_mid();
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
